// File: rtl/puf_challenge_sequencer.sv
// ----------------------------------------------------------------------------
// puf_challenge_sequencer
//
// Purpose:
//   Runs a serial PUF through NUM_CHALLENGES challenges. It seeds the external
//   8-bit challenge LFSR, presents each LFSR value to the PUF core with a
//   one-cycle trigger, and waits for the response (bounded by TIMEOUT cycles).
//   It then emits a {challenge, response} record on a valid/ready stream and
//   steps the LFSR. Every output is driven from a register.
//
// Parameters:
//   NUM_CHALLENGES  challenges per run (1..256; 256 ends when count wraps to 0)
//   TIMEOUT         maximum WAIT_RESP cycles before a forced record (1..255)
//
// Optional feature (compile-time macro RESP_SIGNATURE_EN):
//   defined   : resp_sig shifts in each accepted out_response; it is cleared
//               on an accepted start and holds after the run ends.
//   undefined : resp_sig is tied to 16'h0000 and no shift register exists.
//
// Ports:
//   clock, reset     rising-edge clock; asynchronous active-high reset
//   start, seed      begin a run (accepted in IDLE only) with the given seed
//   abort            synchronous return to IDLE from any state, beats start
//   lfsr_seed        seed presented to the LFSR (8'h00 replaced by 8'h01)
//   lfsr_load        one-cycle LFSR load pulse
//   lfsr_increment   one-cycle LFSR step pulse
//   lfsr_state       current LFSR value
//   puf_challenge    challenge held stable to the PUF core
//   puf_trigger      one-cycle PUF evaluate pulse
//   puf_ready        PUF response valid (level or pulse)
//   puf_response     PUF response bit
//   out_valid/ready  record stream handshake
//   out_challenge    record challenge
//   out_response     record response bit
//   out_timeout      record was forced by the response timeout
//   busy             run in progress (every state except IDLE and DONE)
//   done             one-cycle pulse at normal run end
//   count            records accepted this run
//   err_timeout      sticky: a timeout happened this run
//   resp_sig         response signature (see optional feature)
// ----------------------------------------------------------------------------
module puf_challenge_sequencer #(
    parameter int NUM_CHALLENGES = 16,
    parameter int TIMEOUT        = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  seed,
    output logic [7:0]  lfsr_seed,
    output logic        lfsr_load,
    output logic        lfsr_increment,
    input  logic [7:0]  lfsr_state,
    output logic [7:0]  puf_challenge,
    output logic        puf_trigger,
    input  logic        puf_ready,
    input  logic        puf_response,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_challenge,
    output logic        out_response,
    output logic        out_timeout,
    output logic        busy,
    output logic        done,
    output logic [7:0]  count,
    output logic        err_timeout,
    output logic [15:0] resp_sig
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_TRIGGER,
        S_WAIT_RESP,
        S_EMIT,
        S_STEP,
        S_DONE
    } state_t;

    // Truncation is intended: NUM_CHALLENGES=256 maps to 0, matching the
    // 8-bit count wrapping on the final handshake.
    localparam logic [7:0] LP_LAST_COUNT = 8'(NUM_CHALLENGES);
    localparam logic [7:0] LP_TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_seed,      w_seed;
    logic [7:0] r_puf_chal,  w_puf_chal;
    logic [7:0] r_timer,     w_timer;
    logic [7:0] r_out_chal,  w_out_chal;
    logic       r_out_resp,  w_out_resp;
    logic       r_out_to,    w_out_to;
    logic [7:0] r_count,     w_count;
    logic       r_err_to,    w_err_to;
    logic       r_lfsr_load;
    logic       r_lfsr_inc;
    logic       r_puf_trig;
    logic       r_out_valid;
    logic       r_busy;
    logic       r_done;
    logic       w_handshake;

    // out_valid is high exactly while in EMIT, so the state stands in for it.
    assign w_handshake = (r_state == S_EMIT) && out_ready && !abort;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-register-value logic
    // ------------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_seed       = r_seed;
        w_puf_chal   = r_puf_chal;
        w_timer      = r_timer;
        w_out_chal   = r_out_chal;
        w_out_resp   = r_out_resp;
        w_out_to     = r_out_to;
        w_count      = r_count;
        w_err_to     = r_err_to;

        if (abort) begin
            // Abort wins over everything, including a start or a handshake
            // in the same cycle; count and err_timeout are left as they are.
            w_next_state = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // The LFSR locks up at zero, so a zero seed is bumped.
                        w_seed       = (seed == 8'h00) ? 8'h01 : seed;
                        w_count      = 8'h00;
                        w_err_to     = 1'b0;
                        w_next_state = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_next_state = S_SETTLE;
                end
                S_SETTLE: begin
                    // Capture on the edge into TRIGGER so the challenge is
                    // already stable in the cycle the trigger pulse is high.
                    w_puf_chal   = lfsr_state;
                    w_next_state = S_TRIGGER;
                end
                S_TRIGGER: begin
                    w_timer      = 8'h00;
                    w_next_state = S_WAIT_RESP;
                end
                S_WAIT_RESP: begin
                    if (puf_ready) begin
                        // A response in the final timer cycle still counts.
                        w_out_chal   = r_puf_chal;
                        w_out_resp   = puf_response;
                        w_out_to     = 1'b0;
                        w_next_state = S_EMIT;
                    end else if (r_timer == LP_TMO_LAST) begin
                        w_out_chal   = r_puf_chal;
                        w_out_resp   = 1'b0;
                        w_out_to     = 1'b1;
                        w_err_to     = 1'b1;
                        w_next_state = S_EMIT;
                    end else begin
                        w_timer = r_timer + 8'd1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        w_count      = r_count + 8'd1;
                        w_next_state = ((r_count + 8'd1) == LP_LAST_COUNT) ? S_DONE : S_STEP;
                    end
                end
                S_STEP: begin
                    w_next_state = S_SETTLE;
                end
                S_DONE: begin
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered datapath and outputs. Pulse and status outputs are decoded
    // from the next state so they line up with the state they belong to.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seed      <= 8'h00;
            r_puf_chal  <= 8'h00;
            r_timer     <= 8'h00;
            r_out_chal  <= 8'h00;
            r_out_resp  <= 1'b0;
            r_out_to    <= 1'b0;
            r_count     <= 8'h00;
            r_err_to    <= 1'b0;
            r_lfsr_load <= 1'b0;
            r_lfsr_inc  <= 1'b0;
            r_puf_trig  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_seed      <= w_seed;
            r_puf_chal  <= w_puf_chal;
            r_timer     <= w_timer;
            r_out_chal  <= w_out_chal;
            r_out_resp  <= w_out_resp;
            r_out_to    <= w_out_to;
            r_count     <= w_count;
            r_err_to    <= w_err_to;
            r_lfsr_load <= (w_next_state == S_LOAD);
            r_lfsr_inc  <= (w_next_state == S_STEP);
            r_puf_trig  <= (w_next_state == S_TRIGGER);
            r_out_valid <= (w_next_state == S_EMIT);
            r_busy      <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
            r_done      <= (w_next_state == S_DONE);
        end
    end

`ifdef RESP_SIGNATURE_EN
    logic [15:0] r_resp_sig;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_sig <= 16'h0000;
        end else if ((r_state == S_IDLE) && start && !abort) begin
            r_resp_sig <= 16'h0000;
        end else if (w_handshake) begin
            r_resp_sig <= {r_resp_sig[14:0], r_out_resp};
        end
    end

    assign resp_sig = r_resp_sig;
`else
    assign resp_sig = 16'h0000;
`endif

    assign lfsr_seed      = r_seed;
    assign lfsr_load      = r_lfsr_load;
    assign lfsr_increment = r_lfsr_inc;
    assign puf_challenge  = r_puf_chal;
    assign puf_trigger    = r_puf_trig;
    assign out_valid      = r_out_valid;
    assign out_challenge  = r_out_chal;
    assign out_response   = r_out_resp;
    assign out_timeout    = r_out_to;
    assign busy           = r_busy;
    assign done           = r_done;
    assign count          = r_count;
    assign err_timeout    = r_err_to;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// ----------------------------------------------------------------------------
// tb_puf_challenge_sequencer
//
// Directed bench for puf_challenge_sequencer with NUM_CHALLENGES=4, TIMEOUT=4.
// The bench owns an 8-bit Fibonacci LFSR (feedback s7^s5^s4^s3 into bit 0):
//   A5 -> 4A -> 95 -> 2A,  5A -> B4.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_puf_challenge_sequencer;

    localparam int NUM = 4;
    localparam int TMO = 4;

`ifdef RESP_SIGNATURE_EN
    localparam logic [15:0] EXP_SIG = 16'h000B;
`else
    localparam logic [15:0] EXP_SIG = 16'h0000;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  seed;
    logic [7:0]  lfsr_seed;
    logic        lfsr_load;
    logic        lfsr_increment;
    logic [7:0]  lfsr_state;
    logic [7:0]  puf_challenge;
    logic        puf_trigger;
    logic        puf_ready;
    logic        puf_response;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_challenge;
    logic        out_response;
    logic        out_timeout;
    logic        busy;
    logic        done;
    logic [7:0]  count;
    logic        err_timeout;
    logic [15:0] resp_sig;

    int n_pass   = 0;
    int n_checks = 0;
    int n_load   = 0;
    int n_inc    = 0;
    int n_done   = 0;

    logic [7:0] m_lfsr = 8'h00;

    puf_challenge_sequencer #(
        .NUM_CHALLENGES (NUM),
        .TIMEOUT        (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .seed           (seed),
        .lfsr_seed      (lfsr_seed),
        .lfsr_load      (lfsr_load),
        .lfsr_increment (lfsr_increment),
        .lfsr_state     (lfsr_state),
        .puf_challenge  (puf_challenge),
        .puf_trigger    (puf_trigger),
        .puf_ready      (puf_ready),
        .puf_response   (puf_response),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_challenge  (out_challenge),
        .out_response   (out_response),
        .out_timeout    (out_timeout),
        .busy           (busy),
        .done           (done),
        .count          (count),
        .err_timeout    (err_timeout),
        .resp_sig       (resp_sig)
    );

    always #5 clock = ~clock;

    // External LFSR and pulse counters.
    assign lfsr_state = m_lfsr;
    always @(posedge clock) begin
        if (lfsr_load)
            m_lfsr <= lfsr_seed;
        else if (lfsr_increment)
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (lfsr_load)      n_load++;
        if (lfsr_increment) n_inc++;
        if (done)           n_done++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic abort_run();
        abort = 1'b1;
        @(negedge clock);
        abort     = 1'b0;
        out_ready = 1'b0;
        puf_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        n_checks++;
        if ({busy, done, out_valid, puf_trigger, lfsr_load, lfsr_increment, err_timeout, out_timeout, out_response} !== 9'h000) begin
            $display("FAIL reset_flags: got %b expected 000000000",
                     {busy, done, out_valid, puf_trigger, lfsr_load, lfsr_increment, err_timeout, out_timeout, out_response});
        end else n_pass++;
        n_checks++;
        if ({count, lfsr_seed, puf_challenge, out_challenge} !== 32'h0) begin
            $display("FAIL reset_data: got %h expected 00000000", {count, lfsr_seed, puf_challenge, out_challenge});
        end else n_pass++;
        n_checks++;
        if (resp_sig !== 16'h0000) begin
            $display("FAIL reset_sig: got %h expected 0000", resp_sig);
        end else n_pass++;
        reset = 1'b0;
        tick(2);
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL idle_no_start: busy got %b expected 0", busy);
        end else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_normal_run();
        logic [7:0] exp_chal [4] = '{8'hA5, 8'h4A, 8'h95, 8'h2A};
        logic       exp_resp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int l0 = n_load;
        int i0 = n_inc;
        int d0 = n_done;
        seed      = 8'hA5;
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if ({lfsr_load, busy, lfsr_seed} !== {1'b1, 1'b1, 8'hA5}) begin
            $display("FAIL run_load: got load=%b busy=%b seed=%h expected 1 1 a5", lfsr_load, busy, lfsr_seed);
        end else n_pass++;
        tick(1);
        n_checks++;
        if (puf_trigger !== 1'b0) begin
            $display("FAIL run_settle: trigger got %b expected 0", puf_trigger);
        end else n_pass++;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({puf_trigger, puf_challenge} !== {1'b1, exp_chal[i]}) begin
                $display("FAIL run_trigger[%0d]: got trig=%b chal=%h expected 1 %h", i, puf_trigger, puf_challenge, exp_chal[i]);
            end else n_pass++;
            tick(2);
            puf_ready    = 1'b1;
            puf_response = exp_resp[i];
            tick(1);
            puf_ready = 1'b0;
            n_checks++;
            if ({out_valid, out_challenge, out_response, out_timeout} !== {1'b1, exp_chal[i], exp_resp[i], 1'b0}) begin
                $display("FAIL run_record[%0d]: got v=%b c=%h r=%b t=%b expected 1 %h %b 0",
                         i, out_valid, out_challenge, out_response, out_timeout, exp_chal[i], exp_resp[i]);
            end else n_pass++;
            tick(1);
            if (i < 3) begin
                n_checks++;
                if ({lfsr_increment, busy, out_valid} !== 3'b110) begin
                    $display("FAIL run_step[%0d]: got inc=%b busy=%b valid=%b expected 1 1 0", i, lfsr_increment, busy, out_valid);
                end else n_pass++;
                tick(2);
            end else begin
                n_checks++;
                if ({done, busy, count} !== {1'b1, 1'b0, 8'd4}) begin
                    $display("FAIL run_done: got done=%b busy=%b count=%0d expected 1 0 4", done, busy, count);
                end else n_pass++;
            end
        end
        tick(1);
        n_checks++;
        if (done !== 1'b0) begin
            $display("FAIL run_done_pulse: done got %b expected 0 one cycle later", done);
        end else n_pass++;
        n_checks++;
        if ({n_load - l0, n_inc - i0, n_done - d0} !== {32'd1, 32'd3, 32'd1}) begin
            $display("FAIL run_pulses: got load=%0d inc=%0d done=%0d expected 1 3 1", n_load - l0, n_inc - i0, n_done - d0);
        end else n_pass++;
        n_checks++;
        if ({err_timeout, count} !== {1'b0, 8'd4}) begin
            $display("FAIL run_status: got err=%b count=%0d expected 0 4", err_timeout, count);
        end else n_pass++;
        n_checks++;
        if (resp_sig !== EXP_SIG) begin
            $display("FAIL run_sig: got %h expected %h", resp_sig, EXP_SIG);
        end else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_zero_seed();
        out_ready = 1'b0;
        seed      = 8'h00;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if (lfsr_seed !== 8'h01) begin
            $display("FAIL zero_seed: lfsr_seed got %h expected 01", lfsr_seed);
        end else n_pass++;
        tick(2);
        n_checks++;
        if ({puf_trigger, puf_challenge} !== {1'b1, 8'h01}) begin
            $display("FAIL zero_trigger: got trig=%b chal=%h expected 1 01", puf_trigger, puf_challenge);
        end else n_pass++;
        puf_ready    = 1'b1;
        puf_response = 1'b0;
        tick(2);
        puf_ready = 1'b0;
        n_checks++;
        if ({out_valid, out_challenge} !== {1'b1, 8'h01}) begin
            $display("FAIL zero_record: got v=%b c=%h expected 1 01", out_valid, out_challenge);
        end else n_pass++;
        abort_run();
        n_checks++;
        if ({busy, out_valid} !== 2'b00) begin
            $display("FAIL zero_abort_emit: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_timeout();
        int k = 0;
        seed      = 8'h5A;
        out_ready = 1'b1;
        puf_ready = 1'b0;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tick(2);
        n_checks++;
        if ({puf_trigger, puf_challenge} !== {1'b1, 8'h5A}) begin
            $display("FAIL tmo_trigger: got trig=%b chal=%h expected 1 5a", puf_trigger, puf_challenge);
        end else n_pass++;
        for (int t = 0; t < TMO; t++) begin
            tick(1);
            n_checks++;
            if (out_valid !== 1'b0) begin
                $display("FAIL tmo_early[%0d]: out_valid got %b expected 0", t, out_valid);
            end else n_pass++;
        end
        tick(1);
        n_checks++;
        if ({out_valid, out_challenge, out_response, out_timeout, err_timeout} !== {1'b1, 8'h5A, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL tmo_record: got v=%b c=%h r=%b t=%b err=%b expected 1 5a 0 1 1",
                     out_valid, out_challenge, out_response, out_timeout, err_timeout);
        end else n_pass++;
        tick(3);
        n_checks++;
        if ({puf_trigger, puf_challenge} !== {1'b1, 8'hB4}) begin
            $display("FAIL tmo_trigger2: got trig=%b chal=%h expected 1 b4", puf_trigger, puf_challenge);
        end else n_pass++;
        // Response arrives in the last timer cycle and must win.
        tick(TMO);
        puf_ready    = 1'b1;
        puf_response = 1'b1;
        tick(1);
        n_checks++;
        if ({out_valid, out_challenge, out_response, out_timeout, err_timeout} !== {1'b1, 8'hB4, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL tmo_boundary: got v=%b c=%h r=%b t=%b err=%b expected 1 b4 1 0 1",
                     out_valid, out_challenge, out_response, out_timeout, err_timeout);
        end else n_pass++;
        while (done !== 1'b1 && k < 60) begin
            tick(1);
            k++;
        end
        n_checks++;
        if ({done, err_timeout, count} !== {1'b1, 1'b1, 8'd4}) begin
            $display("FAIL tmo_done: got done=%b err=%b count=%0d expected 1 1 4", done, err_timeout, count);
        end else n_pass++;
        puf_ready = 1'b0;
        tick(1);
        n_checks++;
        if ({err_timeout, busy} !== 2'b10) begin
            $display("FAIL tmo_sticky: got err=%b busy=%b expected 1 0", err_timeout, busy);
        end else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        int i0;
        seed         = 8'hC3;
        out_ready    = 1'b0;
        puf_ready    = 1'b1;
        puf_response = 1'b1;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tick(4);
        i0 = n_inc;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if ({out_valid, out_challenge, out_response, out_timeout, lfsr_increment} !== {1'b1, 8'hC3, 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL bp_hold[%0d]: got v=%b c=%h r=%b t=%b inc=%b expected 1 c3 1 0 0",
                         c, out_valid, out_challenge, out_response, out_timeout, lfsr_increment);
            end else n_pass++;
            tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        n_checks++;
        if ({lfsr_increment, out_valid, count, n_inc - i0} !== {1'b1, 1'b0, 8'd1, 32'd0}) begin
            $display("FAIL bp_release: got inc=%b v=%b count=%0d early_inc=%0d expected 1 0 1 0",
                     lfsr_increment, out_valid, count, n_inc - i0);
        end else n_pass++;
        abort_run();
        n_checks++;
        if ({busy, count} !== {1'b0, 8'd1}) begin
            $display("FAIL bp_abort_keep: got busy=%b count=%0d expected 0 1", busy, count);
        end else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_abort();
        int d0 = n_done;
        seed  = 8'h55;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if ({busy, lfsr_load, lfsr_seed} !== {1'b0, 1'b0, 8'hC3}) begin
            $display("FAIL abort_over_start: got busy=%b load=%b seed=%h expected 0 0 c3", busy, lfsr_load, lfsr_seed);
        end else n_pass++;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tick(4);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_checks++;
        if ({busy, out_valid, puf_trigger, done} !== 4'b0000) begin
            $display("FAIL abort_wait: got busy=%b v=%b trig=%b done=%b expected 0 0 0 0", busy, out_valid, puf_trigger, done);
        end else n_pass++;
        tick(3);
        n_checks++;
        if ({out_valid, n_done - d0} !== {1'b0, 32'd0}) begin
            $display("FAIL abort_no_done: got v=%b done_pulses=%0d expected 0 0", out_valid, n_done - d0);
        end else n_pass++;
        seed         = 8'h3C;
        puf_ready    = 1'b1;
        puf_response = 1'b0;
        out_ready    = 1'b0;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tick(2);
        n_checks++;
        if ({puf_trigger, puf_challenge} !== {1'b1, 8'h3C}) begin
            $display("FAIL restart_trigger: got trig=%b chal=%h expected 1 3c", puf_trigger, puf_challenge);
        end else n_pass++;
        tick(2);
        puf_ready = 1'b0;
        n_checks++;
        if ({out_valid, out_challenge, out_response, out_timeout, count} !== {1'b1, 8'h3C, 1'b0, 1'b0, 8'd0}) begin
            $display("FAIL restart_record: got v=%b c=%h r=%b t=%b count=%0d expected 1 3c 0 0 0",
                     out_valid, out_challenge, out_response, out_timeout, count);
        end else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_midrun();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy, puf_trigger, count, lfsr_seed, out_challenge, puf_challenge} !== {3'b000, 32'h0}) begin
            $display("FAIL async_reset: got v=%b busy=%b trig=%b count=%h seed=%h oc=%h pc=%h expected all 0",
                     out_valid, busy, puf_trigger, count, lfsr_seed, out_challenge, puf_challenge);
        end else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        tick(2);
        n_checks++;
        if ({busy, out_valid} !== 2'b00) begin
            $display("FAIL reset_discard: got busy=%b v=%b expected 0 0", busy, out_valid);
        end else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        seed         = 8'h00;
        puf_ready    = 1'b0;
        puf_response = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_normal_run();
        test_zero_seed();
        test_timeout();
        test_backpressure();
        test_abort();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
